// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD timekeeper with a 1 Hz prescaler and a manual set mode.
// Define BCD_TIME_COUNTER_12H_EN for 12-hour display with a PM flag; otherwise hours run 00..23.
module bcd_time_counter #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       pm
);

    localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

`ifdef BCD_TIME_COUNTER_12H_EN
    localparam logic [3:0] HR_T_RST = 4'd1;
    localparam logic [3:0] HR_U_RST = 4'd2;
`else
    localparam logic [3:0] HR_T_RST = 4'd0;
    localparam logic [3:0] HR_U_RST = 4'd0;
`endif

    logic [0:0]    state;
    logic [PW-1:0] presc;

    logic [3:0] sec_t_nxt, sec_u_nxt;
    logic [3:0] min_t_nxt, min_u_nxt;
    logic [3:0] hr_t_nxt, hr_u_nxt;
    logic       sec_last, min_last, hr_last, pm_flip;

    // Successor of each digit pair on its own, with no carry between fields;
    // the sequential block decides which fields actually move.
    always_comb begin
        sec_last  = (sec_t == 4'd5) && (sec_u == 4'd9);
        min_last  = (min_t == 4'd5) && (min_u == 4'd9);
        sec_t_nxt = sec_t;
        sec_u_nxt = sec_u + 4'd1;
        min_t_nxt = min_t;
        min_u_nxt = min_u + 4'd1;
        if (sec_u == 4'd9) begin
            sec_u_nxt = 4'd0;
            sec_t_nxt = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
        end
        if (min_u == 4'd9) begin
            min_u_nxt = 4'd0;
            min_t_nxt = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
        end

        hr_t_nxt = hr_t;
        hr_u_nxt = hr_u + 4'd1;
        pm_flip  = 1'b0;
`ifdef BCD_TIME_COUNTER_12H_EN
        // 12 is the first hour of each half-day, so 12 -> 01 and 11 -> 12 flips PM.
        hr_last = (hr_t == 4'd1) && (hr_u == 4'd1) && pm;
        if ((hr_t == 4'd1) && (hr_u == 4'd2)) begin
            hr_t_nxt = 4'd0;
            hr_u_nxt = 4'd1;
        end else if ((hr_t == 4'd1) && (hr_u == 4'd1)) begin
            hr_t_nxt = 4'd1;
            hr_u_nxt = 4'd2;
            pm_flip  = 1'b1;
        end else if (hr_u == 4'd9) begin
            hr_t_nxt = hr_t + 4'd1;
            hr_u_nxt = 4'd0;
        end
`else
        hr_last = (hr_t == 4'd2) && (hr_u == 4'd3);
        if (hr_last) begin
            hr_t_nxt = 4'd0;
            hr_u_nxt = 4'd0;
        end else if (hr_u == 4'd9) begin
            hr_t_nxt = hr_t + 4'd1;
            hr_u_nxt = 4'd0;
        end
`endif
    end

    // Mode switching takes priority over counting, so a set_mode rise on a
    // prescaler wrap clears the seconds instead of advancing them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            presc    <= '0;
            hr_t     <= HR_T_RST;
            hr_u     <= HR_U_RST;
            min_t    <= 4'd0;
            min_u    <= 4'd0;
            sec_t    <= 4'd0;
            sec_u    <= 4'd0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            pm       <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            if (state == ST_RUN) begin
                if (set_mode) begin
                    state <= ST_SET;
                    presc <= '0;
                    sec_t <= 4'd0;
                    sec_u <= 4'd0;
                end else if (presc == PRESC_MAX) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    sec_t    <= sec_t_nxt;
                    sec_u    <= sec_u_nxt;
                    if (sec_last) begin
                        min_t <= min_t_nxt;
                        min_u <= min_u_nxt;
                        if (min_last) begin
                            hr_t     <= hr_t_nxt;
                            hr_u     <= hr_u_nxt;
                            pm       <= pm ^ pm_flip;
                            day_wrap <= hr_last;
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc <= '0;
                if (!set_mode) begin
                    state <= ST_RUN;
                end else begin
                    if (inc_min) begin
                        min_t <= min_t_nxt;
                        min_u <= min_u_nxt;
                    end
                    if (inc_hr) begin
                        hr_t <= hr_t_nxt;
                        hr_u <= hr_u_nxt;
                        pm   <= pm ^ pm_flip;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: a seconds-of-day reference model
// feeds a scoreboard that is compared against the DUT after every clock edge.
module tb_bcd_time_counter;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       set_mode;
    logic       inc_hr;
    logic       inc_min;
    logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
    logic       sec_tick, day_wrap, pm;

    logic [26:0] observed;
    logic [26:0] exp_v;
    logic [26:0] sb[$];
    logic [3:0]  stim[$];

    int n_tests  = 0;
    int n_failed = 0;

    int m_tod   = 0;
    int m_presc = 0;
    bit m_set   = 0;

    bcd_time_counter #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_mode (set_mode),
        .inc_hr   (inc_hr),
        .inc_min  (inc_min),
        .hr_t     (hr_t),
        .hr_u     (hr_u),
        .min_t    (min_t),
        .min_u    (min_u),
        .sec_t    (sec_t),
        .sec_u    (sec_u),
        .sec_tick (sec_tick),
        .day_wrap (day_wrap),
        .pm       (pm)
    );

    assign observed = {hr_t, hr_u, min_t, min_u, sec_t, sec_u, sec_tick, day_wrap, pm};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Display value for a time of day held as seconds since midnight.
    function automatic logic [26:0] expect_vec(input int t, input bit tick, input bit dw);
        int h, m, s, hd;
        bit p;
        h  = t / 3600;
        m  = (t / 60) % 60;
        s  = t % 60;
        p  = 1'b0;
`ifdef BCD_TIME_COUNTER_12H_EN
        hd = ((h % 12) == 0) ? 12 : (h % 12);
        p  = (h >= 12);
`else
        hd = h;
`endif
        return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), tick, dw, p};
    endfunction

    // Drive one cycle of {rst, set_mode, inc_hr, inc_min}, predict the result and queue it.
    task automatic step(input logic [3:0] v);
        bit tick, dw;
        int h, m;
        tick     = 1'b0;
        dw       = 1'b0;
        rst      = v[3];
        set_mode = v[2];
        inc_hr   = v[1];
        inc_min  = v[0];
        if (v[3]) begin
            m_tod   = 0;
            m_presc = 0;
            m_set   = 1'b0;
        end else if (!m_set) begin
            if (v[2]) begin
                m_set   = 1'b1;
                m_presc = 0;
                m_tod   = m_tod - (m_tod % 60);
            end else if (m_presc == DIV - 1) begin
                m_presc = 0;
                tick    = 1'b1;
                dw      = (m_tod == 86399);
                m_tod   = (m_tod + 1) % 86400;
            end else begin
                m_presc = m_presc + 1;
            end
        end else begin
            m_presc = 0;
            if (!v[2]) begin
                m_set = 1'b0;
            end else begin
                h = m_tod / 3600;
                m = (m_tod / 60) % 60;
                if (v[0]) m = (m + 1) % 60;
                if (v[1]) h = (h + 1) % 24;
                m_tod = h * 3600 + m * 60;
            end
        end
        sb.push_back(expect_vec(m_tod, tick, dw));
        @(posedge clk);
        #1;
    endtask

    function automatic void push_run(input int n);
        for (int i = 0; i < n; i++) stim.push_back({2'b00, 2'($urandom_range(0, 3))});
    endfunction

    // Reset to midnight, then dial in hh:mm through set mode and return to run.
    function automatic void push_goto(input int h, input int m);
        stim.push_back(4'b1000);
        stim.push_back(4'b0100);
        for (int i = 0; i < h; i++) stim.push_back(4'b0110);
        for (int i = 0; i < m; i++) stim.push_back(4'b0101);
        stim.push_back(4'b0000);
    endfunction

    task automatic test_reset();
        stim.delete();
        stim.push_back(4'b1000);
        stim.push_back(4'b1111);
        stim.push_back(4'b1000);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL reset step %0d: observed %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    task automatic test_run_count();
        int ticks;
        ticks = 0;
        stim.delete();
        stim.push_back(4'b1000);
        push_run(12);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL run_count step %0d: observed %h expected %h", i, observed, exp_v);
            end
            if (sec_tick === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks != 3) begin
            n_failed++;
            $display("[TB] FAIL run_count ticks: observed %0d expected 3", ticks);
        end
        n_tests++;
`ifdef BCD_TIME_COUNTER_12H_EN
        if (observed[26:3] !== 24'h120003) begin
`else
        if (observed[26:3] !== 24'h000003) begin
`endif
            n_failed++;
            $display("[TB] FAIL run_count time: observed %h", observed[26:3]);
        end
    endtask

    task automatic test_carries();
        int hm[3][2] = '{'{0, 0}, '{0, 59}, '{9, 59}};
        for (int k = 0; k < 3; k++) begin
            stim.delete();
            push_goto(hm[k][0], hm[k][1]);
            push_run(60 * DIV + 2);
            foreach (stim[i]) begin
                step(stim[i]);
                exp_v = sb.pop_front();
                n_tests++;
                if (observed !== exp_v) begin
                    n_failed++;
                    $display("[TB] FAIL carry%0d step %0d: observed %h expected %h", k, i, observed, exp_v);
                end
            end
        end
    endtask

    task automatic test_day_wrap();
        int wraps;
        wraps = 0;
        stim.delete();
        push_goto(23, 59);
        push_run(60 * DIV + 8);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL day_wrap step %0d: observed %h expected %h", i, observed, exp_v);
            end
            if (day_wrap === 1'b1) wraps++;
        end
        n_tests++;
        if (wraps != 1) begin
            n_failed++;
            $display("[TB] FAIL day_wrap count: observed %0d expected 1", wraps);
        end
    endtask

    task automatic test_noon();
        int hs[2] = '{11, 12};
        for (int k = 0; k < 2; k++) begin
            stim.delete();
            push_goto(hs[k], 59);
            push_run(60 * DIV + 2);
            foreach (stim[i]) begin
                step(stim[i]);
                exp_v = sb.pop_front();
                n_tests++;
                if (observed !== exp_v) begin
                    n_failed++;
                    $display("[TB] FAIL noon%0d step %0d: observed %h expected %h", k, i, observed, exp_v);
                end
            end
        end
    endtask

    task automatic test_set_mode();
        stim.delete();
        push_goto(10, 59);
        push_run(37 * DIV + 1);
        stim.push_back(4'b0100);
        stim.push_back(4'b0100);
        stim.push_back(4'b0101);
        stim.push_back(4'b0100);
        stim.push_back(4'b0111);
        for (int i = 0; i < 12; i++) stim.push_back(4'b0110);
        stim.push_back(4'b0110);
        stim.push_back(4'b0100);
        stim.push_back(4'b0000);
        push_run(3 * DIV + 1);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL set_mode step %0d: observed %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    task automatic test_set_on_wrap();
        stim.delete();
        stim.push_back(4'b1000);
        push_run(5 * DIV + DIV - 1);
        stim.push_back(4'b0100);
        stim.push_back(4'b0100);
        stim.push_back(4'b0000);
        push_run(2 * DIV + 1);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL set_on_wrap step %0d: observed %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim.delete();
        push_goto(5, 17);
        push_run(42 * DIV + 2);
        stim.push_back(4'b1000);
        push_run(DIV + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL reset_mid step %0d: observed %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim.delete();
        stim.push_back(4'b1000);
        stim.push_back(4'b0100);
        for (int i = 0; i < 61; i++) stim.push_back(4'b0101);
        for (int i = 0; i < 25; i++) stim.push_back(4'b0110);
        for (int i = 0; i < 3; i++) stim.push_back(4'b0111);
        stim.push_back(4'b0000);
        push_run(2 * DIV + 1);
        foreach (stim[i]) begin
            step(stim[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (observed !== exp_v) begin
                n_failed++;
                $display("[TB] FAIL back_to_back step %0d: observed %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        set_mode = 1'b0;
        inc_hr   = 1'b0;
        inc_min  = 1'b0;
        test_reset();
        test_run_count();
        test_carries();
        test_day_wrap();
        test_noon();
        test_set_mode();
        test_set_on_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
